// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

   localparam int STARVE_W = 4;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_IF,
      ARB_DM
   } arb_state_e;

   typedef enum logic {
      OWN_IF,
      OWN_DM
   } arb_owner_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data grants issued while a fetch waits; force_if tells
// the arbiter to let the fetch through next.
module mem_arb_starve_ctr
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst_l,
   input  logic dm_gnt,
   input  logic if_gnt,
   input  logic if_pending,
   output logic force_if
);

   localparam logic [STARVE_W-1:0] MAX_CNT = STARVE_W'(STARVE_MAX);

   logic [STARVE_W-1:0] cnt;

   assign force_if = (cnt >= MAX_CNT);

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         cnt <= '0;
      end else if (if_gnt) begin
         cnt <= '0;
      end else if (dm_gnt && if_pending && !force_if) begin
         // NOTE: state registers always use <= so every flop samples pre-edge values.
         cnt <= cnt + 4'd1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one single-port memory, holding the
// memory-side fields until ack and returning registered data to the owner.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_l,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic              o_if_gnt,
   output logic              o_if_done,
   output logic [DATA_W-1:0] o_if_rdata,
   input  logic              i_dm_req,
   input  logic              i_dm_we,
   input  logic [ADDR_W-1:0] i_dm_addr,
   input  logic [DATA_W-1:0] i_dm_wdata,
   output logic              o_dm_gnt,
   output logic              o_dm_done,
   output logic [DATA_W-1:0] o_dm_rdata,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic              i_mem_ack,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   arb_state_e state;
   arb_owner_e owner;
   logic       force_if;

   mem_arb_starve_ctr #(
      .STARVE_MAX(STARVE_MAX)
   ) u_starve (
      .clk       (i_clk),
      .rst_l     (i_rst_l),
      .dm_gnt    (o_dm_gnt),
      .if_gnt    (o_if_gnt),
      .if_pending(i_if_req),
      .force_if  (force_if)
   );

   // Grants are combinational and masked by reset so nothing is accepted while held.
   always_comb begin
      // NOTE: defaults first so every path assigns both grants and no latch is inferred.
      o_dm_gnt = 1'b0;
      o_if_gnt = 1'b0;
      if (state == ARB_IDLE && i_rst_l) begin
         if (i_dm_req && (!i_if_req || !force_if)) begin
            o_dm_gnt = 1'b1;
         end else if (i_if_req) begin
            o_if_gnt = 1'b1;
         end
      end
   end

   assign owner = (state == ARB_DM) ? OWN_DM : OWN_IF;

   always_ff @(posedge i_clk or negedge i_rst_l) begin
      if (!i_rst_l) begin
         // NOTE: only control and output registers exist here; all get a defined reset value.
         state       <= ARB_IDLE;
         o_mem_req   <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_if_done   <= 1'b0;
         o_dm_done   <= 1'b0;
         o_if_rdata  <= '0;
         o_dm_rdata  <= '0;
      end else begin
         o_if_done <= 1'b0;
         o_dm_done <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (o_dm_gnt) begin
                  state      <= ARB_DM;
                  o_mem_req  <= 1'b1;
                  o_mem_we   <= i_dm_we;
                  o_mem_addr <= i_dm_addr;
                  if (i_dm_we) begin
                     o_mem_wdata <= i_dm_wdata;
                  end
               end else if (o_if_gnt) begin
                  state      <= ARB_IF;
                  o_mem_req  <= 1'b1;
                  o_mem_we   <= 1'b0;
                  o_mem_addr <= i_if_addr;
               end
            end
            ARB_IF, ARB_DM: begin
               if (i_mem_ack) begin
                  state     <= ARB_IDLE;
                  o_mem_req <= 1'b0;
                  o_mem_we  <= 1'b0;
                  if (owner == OWN_IF) begin
                     o_if_rdata <= i_mem_rdata;
                     o_if_done  <= 1'b1;
                  end else begin
                     o_dm_rdata <= o_mem_we ? '0 : i_mem_rdata;
                     o_dm_done  <= 1'b1;
                  end
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single accesses against a
// bench memory with programmable wait states, plus multi-cycle corner sequences.
module tb_mem_port_arbiter;

   typedef struct {
      bit          is_dm;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          wait_cyc;
      logic [31:0] exp_rdata;
   } vec_t;

   logic        clk;
   logic        rst_l;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_done;
   logic [31:0] if_rdata;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_gnt;
   logic        dm_done;
   logic [31:0] dm_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int          n_checks;
   int          n_fail;
   int          wait_cyc;
   int          ack_cnt;
   bit          force_ack;
   logic [31:0] mem [0:255];
   vec_t        vecs [8];

   mem_port_arbiter #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .STARVE_MAX(2)
   ) dut (
      .i_clk      (clk),
      .i_rst_l    (rst_l),
      .i_if_req   (if_req),
      .i_if_addr  (if_addr),
      .o_if_gnt   (if_gnt),
      .o_if_done  (if_done),
      .o_if_rdata (if_rdata),
      .i_dm_req   (dm_req),
      .i_dm_we    (dm_we),
      .i_dm_addr  (dm_addr),
      .i_dm_wdata (dm_wdata),
      .o_dm_gnt   (dm_gnt),
      .o_dm_done  (dm_done),
      .o_dm_rdata (dm_rdata),
      .o_mem_req  (mem_req),
      .o_mem_we   (mem_we),
      .o_mem_addr (mem_addr),
      .o_mem_wdata(mem_wdata),
      .i_mem_ack  (mem_ack),
      .i_mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench memory: acks after wait_cyc extra cycles, updated on the falling edge.
   always @(negedge clk) begin
      if (force_ack) begin
         mem_ack   = 1'b1;
         mem_rdata = 32'hdeadbeef;
      end else if (!rst_l || !mem_req) begin
         mem_ack = 1'b0;
         ack_cnt = 0;
      end else if (!mem_ack) begin
         if (ack_cnt >= wait_cyc) begin
            mem_ack = 1'b1;
            if (mem_we) begin
               mem[mem_addr[9:2]] = mem_wdata;
               mem_rdata          = 32'h0;
            end else begin
               mem_rdata = mem[mem_addr[9:2]];
            end
         end else begin
            ack_cnt++;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      wait_cyc = v.wait_cyc;
      if (v.is_dm) begin
         dm_req   = 1'b1;
         dm_we    = v.we;
         dm_addr  = v.addr;
         dm_wdata = v.wdata;
      end else begin
         if_req  = 1'b1;
         if_addr = v.addr;
      end
      #1;
      check("gnt", v.is_dm ? dm_gnt : if_gnt, 32'd1);
      tick();
      dm_req = 1'b0;
      if_req = 1'b0;
      dm_we  = 1'b0;
      check("mem_req", {31'd0, mem_req}, 32'd1);
      check("mem_addr", mem_addr, v.addr);
      check("mem_we", {31'd0, mem_we}, {31'd0, v.we});
      if (v.we) check("mem_wdata", mem_wdata, v.wdata);
      n = 1;
      while (!(v.is_dm ? dm_done : if_done) && n < 20) begin
         tick();
         n++;
      end
      check("done_latency", n, v.wait_cyc + 2);
      check("rdata", v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
      tick();
      check("done_single_pulse", {31'd0, v.is_dm ? dm_done : if_done}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          seen;
      int          g;
      int          n;
      int          got [6];
      int          exp_order [6];

      n_checks  = 0;
      n_fail    = 0;
      force_ack = 1'b0;
      wait_cyc  = 0;
      ack_cnt   = 0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      if_req    = 1'b0;
      if_addr   = 32'h0;
      dm_req    = 1'b0;
      dm_we     = 1'b0;
      dm_addr   = 32'h0;
      dm_wdata  = 32'h0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[1] = 32'hfeedc3b7;
      mem[4] = 32'h0badf00d;

      vecs[0] = '{1'b0, 1'b0, 32'h04, 32'h0,        1, 32'hfeedc3b7};
      vecs[1] = '{1'b1, 1'b1, 32'h14, 32'h11,       0, 32'h0};
      vecs[2] = '{1'b1, 1'b0, 32'h14, 32'h0,        2, 32'h11};
      vecs[3] = '{1'b0, 1'b0, 32'h14, 32'h0,        0, 32'h11};
      vecs[4] = '{1'b1, 1'b1, 32'h08, 32'hfeedbeef, 1, 32'h0};
      vecs[5] = '{1'b1, 1'b0, 32'h08, 32'h0,        0, 32'hfeedbeef};
      vecs[6] = '{1'b0, 1'b0, 32'h10, 32'h0,        3, 32'h0badf00d};
      vecs[7] = '{1'b1, 1'b0, 32'h04, 32'h0,        0, 32'hfeedc3b7};

      // Reset held with a fetch request pending: everything stays at zero.
      rst_l  = 1'b0;
      if_req = 1'b1;
      repeat (3) tick();
      check("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
      check("rst_dm_gnt", {31'd0, dm_gnt}, 32'd0);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_dones", {30'd0, if_done, dm_done}, 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_dm_rdata", dm_rdata, 32'd0);
      if_req = 1'b0;
      rst_l  = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Ack while idle must be ignored and the rdata registers must hold.
      force_ack = 1'b1;
      seen      = 1'b0;
      repeat (4) begin
         tick();
         if (if_done || dm_done || mem_req || if_gnt || dm_gnt) seen = 1'b1;
      end
      force_ack = 1'b0;
      @(negedge clk);
      tick();
      check("spurious_no_activity", {31'd0, seen}, 32'd0);
      check("spurious_if_rdata_hold", if_rdata, 32'h0badf00d);
      check("spurious_dm_rdata_hold", dm_rdata, 32'hfeedc3b7);

      // Simultaneous fetch and data write: data first, fetch in the next idle cycle.
      wait_cyc = 1;
      if_req   = 1'b1;
      if_addr  = 32'h10;
      dm_req   = 1'b1;
      dm_we    = 1'b1;
      dm_addr  = 32'h08;
      dm_wdata = 32'hfeedbeef;
      #1;
      check("simul_dm_gnt", {31'd0, dm_gnt}, 32'd1);
      check("simul_if_gnt", {31'd0, if_gnt}, 32'd0);
      tick();
      dm_req = 1'b0;
      dm_we  = 1'b0;
      check("simul_mem_we", {31'd0, mem_we}, 32'd1);
      check("simul_mem_addr", mem_addr, 32'h08);
      check("simul_mem_wdata", mem_wdata, 32'hfeedbeef);
      seen = 1'b0;
      n    = 0;
      while (!dm_done && n < 20) begin
         if (if_gnt) seen = 1'b1;
         tick();
         n++;
      end
      check("simul_no_if_gnt_while_busy", {31'd0, seen}, 32'd0);
      check("simul_dm_done", {31'd0, dm_done}, 32'd1);
      check("simul_dm_rdata", dm_rdata, 32'h0);
      check("simul_if_gnt_next_idle", {31'd0, if_gnt}, 32'd1);
      tick();
      if_req = 1'b0;
      check("simul_if_mem_addr", mem_addr, 32'h10);
      n = 0;
      while (!if_done && n < 20) begin
         tick();
         n++;
      end
      check("simul_if_rdata", if_rdata, 32'h0badf00d);
      tick();

      // Starvation with STARVE_MAX=2 and zero-wait memory.
      exp_order = '{1, 1, 0, 1, 1, 0};
      for (int i = 0; i < 6; i++) got[i] = 2;
      wait_cyc = 0;
      dm_addr  = 32'h14;
      dm_we    = 1'b0;
      if_addr  = 32'h04;
      dm_req   = 1'b1;
      if_req   = 1'b1;
      #1;
      g = 0;
      n = 0;
      while (g < 6 && n < 60) begin
         if (dm_gnt) begin
            got[g] = 1;
            g++;
         end else if (if_gnt) begin
            got[g] = 0;
            g++;
         end
         tick();
         n++;
      end
      dm_req = 1'b0;
      if_req = 1'b0;
      for (int i = 0; i < 6; i++) check($sformatf("starve_order_%0d", i), got[i], exp_order[i]);
      repeat (4) tick();

      // Reset in the middle of a data access: mem_req drops at once, no done.
      wait_cyc = 10;
      dm_req   = 1'b1;
      dm_we    = 1'b0;
      dm_addr  = 32'h04;
      tick();
      dm_req = 1'b0;
      check("midrst_mem_req_before", {31'd0, mem_req}, 32'd1);
      #2;
      rst_l = 1'b0;
      #1;
      check("midrst_mem_req_async", {31'd0, mem_req}, 32'd0);
      #4;
      rst_l = 1'b1;
      seen  = 1'b0;
      repeat (12) begin
         tick();
         if (dm_done || if_done || mem_req) seen = 1'b1;
      end
      check("midrst_no_done", {31'd0, seen}, 32'd0);
      check("midrst_dm_rdata_cleared", dm_rdata, 32'd0);

      run_vec(vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
